// File: rtl/softmax_ctrl_pkg.sv
// Shared state encoding and default arithmetic latencies for the softmax sequencer.
package softmax_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P1_ISSUE,
        P1_DRAIN,
        RECIP,
        P2_ISSUE,
        P2_DRAIN,
        DONE
    } state_t;

    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_EXP_LAT = 4;
    localparam int DEF_ACC_LAT = 2;
    localparam int DEF_MUL_LAT = 3;

endpackage

// File: rtl/sched_delay_line.sv
// Valid+address shift register tracking in-flight reads, with synchronous flush.
module sched_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr,
    output logic         out_valid,
    output logic [W-1:0] out_addr,
    output logic         empty
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     addr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else if (flush) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            vld[0]    <= in_valid;
            addr_q[0] <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i]    <= vld[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

    // Empty means nothing is queued behind the entry currently presented at the output.
    always_comb begin
        empty = 1'b1;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            if (vld[i]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/softmax_pipe_scheduler.sv
// Pipelined two-pass softmax sequencer: exp/accumulate pass, reciprocal, multiply pass.
// Optional SOFTMAX_PERF_CNT_EN adds a perf_cycles busy-cycle counter output.
module softmax_pipe_scheduler
    import softmax_ctrl_pkg::*;
#(
    parameter int TOTAL_VALUES = 1024,
    parameter int ADDR_W       = $clog2(TOTAL_VALUES),
    parameter int RD_LAT       = DEF_RD_LAT,
    parameter int EXP_LAT      = DEF_EXP_LAT,
    parameter int ACC_LAT      = DEF_ACC_LAT,
    parameter int MUL_LAT      = DEF_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram1_en_b,
    output logic [ADDR_W-1:0] ram1_addr_b,
    output logic              ram2_en_a,
    output logic              ram2_we_a,
    output logic [ADDR_W-1:0] ram2_addr_a,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              reci_start,
    input  logic              reci_valid,
    output logic              ram2_en_b,
    output logic [ADDR_W-1:0] ram2_addr_b,
    output logic              ram3_en_a,
    output logic              ram3_we_a,
    output logic [ADDR_W-1:0] ram3_addr_a
`ifdef SOFTMAX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int D1    = RD_LAT + EXP_LAT;
    localparam int D2    = RD_LAT + MUL_LAT;
    localparam int ACC_W = $clog2(ACC_LAT + 1) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_VALUES - 1);
    localparam logic [ACC_W-1:0]  ACC_WAIT  = ACC_W'(ACC_LAT);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ACC_W-1:0]    acc_wait;
    logic                reci_sent;
    logic                issuing, last_addr;
    logic                d1_valid, d1_empty, d2_valid, d2_empty;
    logic [ADDR_W-1:0]   d1_addr, d2_addr;

    assign issuing   = (state == P1_ISSUE) || (state == P2_ISSUE);
    assign last_addr = (addr_cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt  <= '0;
            acc_wait  <= '0;
            reci_sent <= 1'b0;
        end else begin
            if (abort || !issuing || last_addr) addr_cnt <= '0;
            else                                addr_cnt <= addr_cnt + 1'b1;

            // Counts post-drain cycles so the accumulator sum has settled before RECIP.
            if (!abort && state == P1_DRAIN && d1_empty) begin
                if (acc_wait != ACC_WAIT) acc_wait <= acc_wait + 1'b1;
            end else begin
                acc_wait <= '0;
            end

            reci_sent <= !abort && (state == RECIP);
        end
    end

    always_comb begin
        state_n    = state;
        acc_clr    = 1'b0;
        reci_start = 1'b0;
        done       = 1'b0;
        ram1_en_b  = 1'b0;
        ram2_en_b  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    state_n = P1_ISSUE;
                end
            end
            P1_ISSUE: begin
                ram1_en_b = 1'b1;
                if (last_addr) state_n = P1_DRAIN;
            end
            P1_DRAIN: begin
                if (d1_empty && acc_wait == ACC_WAIT) state_n = RECIP;
            end
            RECIP: begin
                reci_start = !reci_sent;
                if (reci_valid) state_n = P2_ISSUE;
            end
            P2_ISSUE: begin
                ram2_en_b = 1'b1;
                if (last_addr) state_n = P2_DRAIN;
            end
            P2_DRAIN: begin
                if (d2_empty) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            acc_clr = 1'b0;
            done    = 1'b0;
        end
    end

    assign busy        = (state != IDLE);
    assign ram1_addr_b = (state == P1_ISSUE) ? addr_cnt : '0;
    assign ram2_addr_b = (state == P2_ISSUE) ? addr_cnt : '0;

    sched_delay_line #(.DEPTH(D1), .W(ADDR_W)) u_p1_dly (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (ram1_en_b),
        .in_addr   (ram1_addr_b),
        .out_valid (d1_valid),
        .out_addr  (d1_addr),
        .empty     (d1_empty)
    );

    sched_delay_line #(.DEPTH(D2), .W(ADDR_W)) u_p2_dly (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (ram2_en_b),
        .in_addr   (ram2_addr_b),
        .out_valid (d2_valid),
        .out_addr  (d2_addr),
        .empty     (d2_empty)
    );

    assign ram2_en_a   = d1_valid;
    assign ram2_we_a   = d1_valid;
    assign acc_en      = d1_valid;
    assign ram2_addr_a = d1_addr;
    assign ram3_en_a   = d2_valid;
    assign ram3_we_a   = d2_valid;
    assign ram3_addr_a = d2_addr;

`ifdef SOFTMAX_PERF_CNT_EN
    logic [31:0] run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                run_cnt     <= '0;
                perf_cycles <= '0;
            end else if (busy && run_cnt != '1) begin
                run_cnt <= run_cnt + 1'b1;
            end
            // The DONE cycle is busy too, so it is folded into the latched value.
            if (done) perf_cycles <= (run_cnt == '1) ? '1 : run_cnt + 1'b1;
        end
    end
`endif

endmodule
